// File: rtl/data_mem_ctrl.sv
// Byte/half/word data memory with little-endian lanes, load extension, misalignment
// detection and a configurable read latency behind a valid/ready request handshake.
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 32,
    parameter int RD_LATENCY  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] address,
    input  logic              memRead_enable,
    input  logic              memWrite_enable,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [31:0]       write_data,
    output logic              resp_valid,
    output logic [31:0]       data_out,
    output logic              misalign_err
);
    localparam int         IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAST_CNT = 2'(RD_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WR_RESP, RD_WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        resp_valid_reg, resp_valid_next;
    logic        misalign_reg, misalign_next;
    logic [31:0] data_out_reg, data_out_next;
    logic [1:0]  ld_size_reg;
    logic [1:0]  ld_lane_reg;
    logic        ld_sext_reg;

    logic             accept, req_err, wr_accept, rd_accept;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       byte_en;
    logic [31:0]      wr_word;
    logic [31:0]      rd_word;
    logic [7:0]       lane_byte;
    logic [15:0]      lane_half;
    logic [31:0]      load_result;

    assign req_ready = (state_reg == IDLE) & rst_n;
    assign accept    = req_valid & req_ready;
    assign word_idx  = address[IDX_W+1:2];
    assign req_err   = (size == 2'b11)
                     | ((size == 2'b01) & address[0])
                     | ((size == 2'b10) & (address[1:0] != 2'b00))
                     | (memRead_enable & memWrite_enable);
    assign wr_accept = accept & ~req_err & memWrite_enable;
    assign rd_accept = accept & ~req_err & memRead_enable;

    // Store data is replicated across lanes so each lane only needs its enable.
    always_comb begin
        byte_en = 4'b0000;
        wr_word = write_data;
        case (size)
            2'b00: begin
                byte_en = 4'b0001 << address[1:0];
                wr_word = {4{write_data[7:0]}};
            end
            2'b01: begin
                byte_en = address[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{write_data[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    // One RAM per byte lane keeps byte-enable writes inferable as block RAM.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (wr_accept && byte_en[gi])
                    mem[word_idx] <= wr_word[8*gi +: 8];
                if (rd_accept)
                    rd_byte_reg <= mem[word_idx];
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    always_comb begin
        case (ld_lane_reg)
            2'd0:    lane_byte = rd_word[7:0];
            2'd1:    lane_byte = rd_word[15:8];
            2'd2:    lane_byte = rd_word[23:16];
            default: lane_byte = rd_word[31:24];
        endcase
        lane_half = ld_lane_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (ld_size_reg)
            2'b00:   load_result = {{24{ld_sext_reg & lane_byte[7]}}, lane_byte};
            2'b01:   load_result = {{16{ld_sext_reg & lane_half[15]}}, lane_half};
            default: load_result = rd_word;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        resp_valid_next = 1'b0;
        misalign_next   = 1'b0;
        data_out_next   = data_out_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_next      = RESP;
                        resp_valid_next = 1'b1;
                        misalign_next   = 1'b1;
                        data_out_next   = 32'd0;
                    end else if (memWrite_enable) begin
                        state_next      = WR_RESP;
                        resp_valid_next = 1'b1;
                        data_out_next   = 32'd0;
                    end else if (memRead_enable) begin
                        state_next = RD_WAIT;
                        cnt_next   = 2'd0;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next      = RESP;
                    cnt_next        = 2'd0;
                    resp_valid_next = 1'b1;
                    data_out_next   = load_result;
                end else begin
                    cnt_next = cnt_reg + 2'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 2'd0;
            resp_valid_reg <= 1'b0;
            misalign_reg   <= 1'b0;
            data_out_reg   <= 32'd0;
            ld_size_reg    <= 2'b00;
            ld_lane_reg    <= 2'b00;
            ld_sext_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            resp_valid_reg <= resp_valid_next;
            misalign_reg   <= misalign_next;
            data_out_reg   <= data_out_next;
            if (rd_accept) begin
                ld_size_reg <= size;
                ld_lane_reg <= address[1:0];
                ld_sext_reg <= sign_ext;
            end
        end
    end

    assign resp_valid   = resp_valid_reg;
    assign data_out     = data_out_reg;
    assign misalign_err = misalign_reg;
endmodule
